// File: rtl/bcd_pkg.sv
// -----------------------------------------------------------------------------
// bcd_pkg
// Shared definitions for the sequential binary-to-BCD converter:
//   - bcd_state_t     : converter FSM states (IDLE, SHIFT, DONE)
//   - BCD_NIBBLE_W    : width of one BCD digit
//   - BCD_ADJ_THRESH  : a digit at or above this value is adjusted before a shift
//   - BCD_ADJ_ADD     : amount added by the adjustment
// -----------------------------------------------------------------------------
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } bcd_state_t;

    localparam int         BCD_NIBBLE_W   = 4;
    localparam logic [3:0] BCD_ADJ_THRESH = 4'd5;
    localparam logic [3:0] BCD_ADJ_ADD    = 4'd3;

endpackage

// File: rtl/bin_to_bcd_seq_if.sv
// -----------------------------------------------------------------------------
// bin_to_bcd_seq_if
// Request/result bundle of the binary-to-BCD converter.
//   start    : conversion request (requester -> converter)
//   bin_in   : unsigned binary value, BIN_W bits (requester -> converter)
//   busy     : converter FSM is not idle (converter -> requester)
//   done     : one-cycle pulse, bcd_out/overflow just updated
//   bcd_out  : 4*DIGITS bits, nibble i holds the 10^i digit
//   overflow : last result did not fit in DIGITS digits
// Modports: master = requester side, slave = converter side.
// -----------------------------------------------------------------------------
interface bin_to_bcd_seq_if #(
    parameter int BIN_W  = 8,
    parameter int DIGITS = 3
);
    logic                  start;
    logic [BIN_W-1:0]      bin_in;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   bcd_out;
    logic                  overflow;

    modport master (
        output start, bin_in,
        input  busy, done, bcd_out, overflow
    );

    modport slave (
        input  start, bin_in,
        output busy, done, bcd_out, overflow
    );
endinterface

// File: rtl/bcd_digit_adjust.sv
// -----------------------------------------------------------------------------
// bcd_digit_adjust
// Combinational double-dabble digit correction: a digit of 5..9 gets 3 added
// so that the following left shift carries correctly into the next digit.
//   din  : 4-bit BCD digit (0..9)
//   dout : adjusted digit (0..4 unchanged, 5..9 -> 8..12)
// The add is 4 bits wide with no carry out; din <= 9 keeps the sum <= 12.
// -----------------------------------------------------------------------------
module bcd_digit_adjust
    import bcd_pkg::*;
(
    input  logic [BCD_NIBBLE_W-1:0] din,
    output logic [BCD_NIBBLE_W-1:0] dout
);

    always_comb begin
        dout = din;
        if (din >= BCD_ADJ_THRESH)
            dout = din + BCD_ADJ_ADD;
    end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// -----------------------------------------------------------------------------
// bin_to_bcd_seq
// Sequential binary-to-BCD converter (shift-and-add-3), one input bit per clock.
// Feeds per-digit seven-segment decoders: each nibble of bcd_out is one digit.
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : bin_to_bcd_seq_if.slave (start, bin_in, busy, done, bcd_out, overflow)
// Timing: start accepted at edge 0 (IDLE only), SHIFT on edges 1..BIN_W, DONE
// for one cycle; bcd_out/overflow/done are registered at the edge leaving DONE,
// so done is high BIN_W+2 cycles after the request. busy = FSM not in IDLE.
// -----------------------------------------------------------------------------
module bin_to_bcd_seq
    import bcd_pkg::*;
#(
    parameter int BIN_W  = 8,
    parameter int DIGITS = 3
) (
    input  logic           clk,
    input  logic           rst,
    bin_to_bcd_seq_if.slave bus
);

    localparam int BCD_W = BCD_NIBBLE_W * DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);

    bcd_state_t         state_q, state_d;
    logic               accept;

    logic [BIN_W-1:0]   shreg_q;     // remaining binary bits, MSB shifts out first
    logic [BCD_W-1:0]   scr_q;       // BCD scratch being built
    logic [BCD_W-1:0]   adj;         // scratch after per-digit add-3
    logic               ovf_scr_q;   // sticky: a bit fell off the top digit
    logic [CNT_W-1:0]   cnt_q;       // shifts still to do

    logic [BCD_W-1:0]   bcd_q;
    logic               ovf_q;
    logic               done_q;

    // Per-digit correction ahead of each shift.
    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adjust u_adj (
            .din  (scr_q[g*BCD_NIBBLE_W +: BCD_NIBBLE_W]),
            .dout (adj  [g*BCD_NIBBLE_W +: BCD_NIBBLE_W])
        );
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    accept  = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                // cnt_q == 1 means this edge performs the last shift
                if (cnt_q == CNT_W'(1))
                    state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Conversion datapath
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg_q   <= '0;
            scr_q     <= '0;
            ovf_scr_q <= 1'b0;
            cnt_q     <= '0;
        end else if (accept) begin
            shreg_q   <= bus.bin_in;
            scr_q     <= '0;
            ovf_scr_q <= 1'b0;
            cnt_q     <= CNT_W'(BIN_W);
        end else if (state_q == SHIFT) begin
            // {adj, shreg} << 1; the MSB of adj leaves the top digit
            scr_q     <= {adj[BCD_W-2:0], shreg_q[BIN_W-1]};
            shreg_q   <= shreg_q << 1;
            ovf_scr_q <= ovf_scr_q | adj[BCD_W-1];
            cnt_q     <= cnt_q - CNT_W'(1);
        end
    end

    // Result registers: only touched when leaving DONE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bcd_q  <= '0;
            ovf_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= (state_q == DONE);
            if (state_q == DONE) begin
                bcd_q <= scr_q;
                ovf_q <= ovf_scr_q;
            end
        end
    end

    assign bus.busy     = (state_q != IDLE);
    assign bus.done     = done_q;
    assign bus.bcd_out  = bcd_q;
    assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// -----------------------------------------------------------------------------
// tb_bin_to_bcd_seq
// Three converters: A (BIN_W=8, DIGITS=3), B (8, 2), C (1, 1).
// A is checked every cycle against a timeline model; B and C per conversion.
// -----------------------------------------------------------------------------
module tb_bin_to_bcd_seq;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    bin_to_bcd_seq_if #(.BIN_W(8), .DIGITS(3)) ifa ();
    bin_to_bcd_seq_if #(.BIN_W(8), .DIGITS(2)) ifb ();
    bin_to_bcd_seq_if #(.BIN_W(1), .DIGITS(1)) ifc ();

    bin_to_bcd_seq #(.BIN_W(8), .DIGITS(3)) u_a (.clk(clk), .rst(rst), .bus(ifa));
    bin_to_bcd_seq #(.BIN_W(8), .DIGITS(2)) u_b (.clk(clk), .rst(rst), .bus(ifb));
    bin_to_bcd_seq #(.BIN_W(1), .DIGITS(1)) u_c (.clk(clk), .rst(rst), .bus(ifc));

    // Decimal digits of v, modulo 10^digits, packed one per nibble.
    function automatic logic [31:0] to_bcd(input int unsigned v, input int digits);
        logic [31:0] r = '0;
        int unsigned x = v;
        for (int i = 0; i < digits; i++) begin
            r[i*4 +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic logic too_big(input int unsigned v, input int digits);
        int unsigned lim = 1;
        for (int i = 0; i < digits; i++) lim = lim * 10;
        return v >= lim;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h @%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- model of A: cycles since acceptance ----------------
    int          ph    = 0;      // 0 idle, 1..9 busy
    logic [7:0]  cap   = '0;
    logic        e_done = 1'b0;
    logic [11:0] e_bcd = '0;
    logic        e_ovf = 1'b0;
    bit          chk_en = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            ph = 0; e_done = 1'b0; e_bcd = '0; e_ovf = 1'b0;
        end else begin
            e_done = 1'b0;
            if (ph == 0) begin
                if (ifa.start) begin cap = ifa.bin_in; ph = 1; end
            end else if (ph == 9) begin
                e_done = 1'b1;
                e_bcd  = 12'(to_bcd(cap, 3));
                e_ovf  = too_big(cap, 3);
                ph     = 0;
            end else begin
                ph++;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("a_busy",     ifa.busy,     ph != 0);
            chk("a_done",     ifa.done,     e_done);
            chk("a_bcd_out",  ifa.bcd_out,  e_bcd);
            chk("a_overflow", ifa.overflow, e_ovf);
        end
    end

    // ---------------- directed conversion tasks ----------------
    task automatic run_a(input logic [7:0] v, input logic [11:0] eb, input logic ee);
        int n = 0, nb = 0;
        bit got = 0;
        @(posedge clk); #1 ifa.start = 1'b1; ifa.bin_in = v;
        @(posedge clk); #1 ifa.start = 1'b0; ifa.bin_in = ~v;   // ignored while busy
        while (!got && n < 40) begin
            @(negedge clk); n++;
            if (ifa.busy) nb++;
            if (ifa.done) got = 1;
        end
        chk("a_latency",     n,  10);
        chk("a_busy_cycles", nb, 9);
        chk("a_result",      ifa.bcd_out,  eb);
        chk("a_result_ovf",  ifa.overflow, ee);
    endtask

    task automatic run_b(input logic [7:0] v, input logic [7:0] eb, input logic ee);
        int n = 0;
        bit got = 0;
        @(posedge clk); #1 ifb.start = 1'b1; ifb.bin_in = v;
        @(posedge clk); #1 ifb.start = 1'b0; ifb.bin_in = ~v;
        while (!got && n < 40) begin
            @(negedge clk); n++;
            if (ifb.done) got = 1;
        end
        chk("b_latency",  n, 10);
        chk("b_result",   ifb.bcd_out,  eb);
        chk("b_overflow", ifb.overflow, ee);
    endtask

    task automatic run_c(input logic v, input logic [3:0] eb);
        int n = 0;
        bit got = 0;
        @(posedge clk); #1 ifc.start = 1'b1; ifc.bin_in = v;
        @(posedge clk); #1 ifc.start = 1'b0; ifc.bin_in = ~v;
        while (!got && n < 20) begin
            @(negedge clk); n++;
            if (ifc.done) got = 1;
        end
        chk("c_latency",  n, 3);
        chk("c_result",   ifc.bcd_out,  eb);
        chk("c_overflow", ifc.overflow, 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] v;
        int nd;
        ifa.start = 1'b0; ifa.bin_in = '0;
        ifb.start = 1'b0; ifb.bin_in = '0;
        ifc.start = 1'b0; ifc.bin_in = '0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy",     ifa.busy,     1'b0);
        chk("rst_done",     ifa.done,     1'b0);
        chk("rst_bcd_out",  ifa.bcd_out,  12'h000);
        chk("rst_overflow", ifa.overflow, 1'b0);
        rst = 1'b0;
        chk_en = 1'b1;

        // directed values with literal expectations
        run_a(8'd0,   12'h000, 1'b0);
        run_a(8'd255, 12'h255, 1'b0);
        run_a(8'd99,  12'h099, 1'b0);
        run_a(8'd100, 12'h100, 1'b0);

        // start held high, bin_in changing every cycle
        @(posedge clk); #1 ifa.start = 1'b1;
        repeat (60) begin
            ifa.bin_in = 8'($urandom);
            @(posedge clk); #1;
        end
        ifa.start = 1'b0;
        repeat (12) @(posedge clk);

        // random single conversions with random gaps
        repeat (25) begin
            v = 8'($urandom);
            run_a(v, 12'(to_bcd(v, 3)), 1'b0);
            repeat ($urandom_range(0, 3)) @(posedge clk);
        end

        // asynchronous reset during SHIFT
        run_a(8'd255, 12'h255, 1'b0);
        @(posedge clk); #1 ifa.start = 1'b1; ifa.bin_in = 8'd200;
        @(posedge clk); #1 ifa.start = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_busy",     ifa.busy,     1'b0);
        chk("arst_done",     ifa.done,     1'b0);
        chk("arst_bcd_out",  ifa.bcd_out,  12'h000);
        chk("arst_overflow", ifa.overflow, 1'b0);
        @(posedge clk); #1 rst = 1'b0;
        nd = 0;
        repeat (15) begin
            @(negedge clk);
            if (ifa.done) nd++;
        end
        chk("arst_no_done", nd, 0);
        run_a(8'd42, 12'h042, 1'b0);

        // two-digit converter
        run_b(8'd99,  8'h99, 1'b0);
        run_b(8'd100, 8'h00, 1'b1);
        run_b(8'd255, 8'h55, 1'b1);
        repeat (8) begin
            v = 8'($urandom);
            run_b(v, 8'(to_bcd(v, 2)), too_big(v, 2));
        end

        // one-bit, one-digit converter
        run_c(1'b1, 4'h1);
        run_c(1'b0, 4'h0);
        run_c(1'b1, 4'h1);

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
